// File: rtl/winograd_pkg.sv
// winograd_pkg: shared Winograd F(4x4,3x3) constants, data type and control states
package winograd_pkg;
  localparam int WG_M = 4;
  localparam int WG_R = 3;
  localparam int WG_T = 6;
  localparam int WG_SCALE = 576;
  typedef logic signed [31:0] data_t;
  typedef enum logic [1:0] {IDLE, CALC_T, CALC_Y, DONE} state_t;
endpackage

// File: rtl/owt_vec_transform.sv
// owt_vec_transform: combinational A^T*v for a 6-vector using shift-add only
module owt_vec_transform #(
  parameter int W = 32
) (
  input  logic [W-1:0] v [0:5],
  output logic [W-1:0] y [0:3]
);
  logic [W-1:0] w_s12, w_d12, w_s34, w_d34;
  assign w_s12 = v[1] + v[2];
  assign w_d12 = v[1] - v[2];
  assign w_s34 = v[3] + v[4];
  assign w_d34 = v[3] - v[4];
  assign y[0] = v[0] + w_s12 + w_s34;
  assign y[1] = w_d12 + (w_d34 << 1);
  assign y[2] = w_s12 + (w_s34 << 2);
  assign y[3] = w_d12 + (w_d34 << 3) + v[5];
endmodule

// File: rtl/output_transform_unit.sv
// output_transform_unit: Winograd output transform Y = A^T*M*A over a 6x6 tile,
// four-state sequencer; Y keeps the x576 scale of the upstream kernel transform.
module output_transform_unit
  import winograd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] m_in  [0:5][0:5],
  output logic [DATA_W-1:0] y_out [0:3][0:3],
  output logic              busy,
  output logic              done
);
  state_t r_state, w_next;
  logic r_done;
  logic [DATA_W-1:0] r_m [0:5][0:5];
  logic [DATA_W-1:0] r_t [0:3][0:5];
  logic [DATA_W-1:0] r_y [0:3][0:3];
  logic [DATA_W-1:0] w_col [0:5][0:5];
  logic [DATA_W-1:0] w_tc [0:5][0:3];
  logic [DATA_W-1:0] w_y [0:3][0:3];
  genvar i, j;
  generate
    for (j = 0; j < 6; j++) begin : g_col
      for (i = 0; i < 6; i++) begin : g_k
        assign w_col[j][i] = r_m[i][j];
      end
      owt_vec_transform #(.W(DATA_W)) u_col (.v(w_col[j]), .y(w_tc[j]));
    end
    for (i = 0; i < 4; i++) begin : g_row
      owt_vec_transform #(.W(DATA_W)) u_row (.v(r_t[i]), .y(w_y[i]));
    end
  endgenerate
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? CALC_T : IDLE;
      CALC_T:  w_next = CALC_Y;
      CALC_Y:  w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done <= 1'b0;
      for (int a = 0; a < 6; a++)
        for (int b = 0; b < 6; b++) r_m[a][b] <= '0;
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 6; b++) r_t[a][b] <= '0;
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++) r_y[a][b] <= '0;
    end else begin
      r_state <= w_next;
      r_done <= (r_state == DONE);
      if (r_state == IDLE && start) r_m <= m_in;
      if (r_state == CALC_T)
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 6; b++) r_t[a][b] <= w_tc[b][a];
      if (r_state == CALC_Y) r_y <= w_y;
    end
  end
  assign y_out = r_y;
  assign busy = (r_state != IDLE);
  assign done = r_done;
endmodule

// File: tb/tb_output_transform_unit.sv
// tb_output_transform_unit: directed vectors with hand-computed Winograd output tiles
module tb_output_transform_unit;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] m_in [0:5][0:5];
  logic [31:0] y_out [0:3][0:3];
  logic busy, done;
  int n_pass = 0, n_tot = 0;
  output_transform_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .m_in(m_in),
    .y_out(y_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_m(input logic [31:0] v);
    for (int a = 0; a < 6; a++)
      for (int b = 0; b < 6; b++) m_in[a][b] = v;
  endtask
  task automatic run_tile();
    start = 1;
    tick();
    start = 0;
    chk("busy_e0", busy, 1);
    tick();
    tick();
    chk("done_e2", done, 0);
    tick();
    chk("done_e3", done, 1);
    chk("busy_e3", busy, 0);
  endtask
  initial begin
    clr_m(0);
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y00", y_out[0][0], 0);
    chk("rst_y33", y_out[3][3], 0);
    rst = 0;
    start = 1;
    rst = 1;
    tick();
    chk("start_in_rst", busy, 0);
    rst = 0;
    start = 0;
    m_in[0][0] = 1;
    run_tile();
    chk("t1_y00", y_out[0][0], 1);
    chk("t1_y01", y_out[0][1], 0);
    chk("t1_y11", y_out[1][1], 0);
    chk("t1_y33", y_out[3][3], 0);
    tick();
    chk("t1_done_once", done, 0);
    clr_m(0);
    m_in[3][3] = 1;
    run_tile();
    chk("t2_y00", y_out[0][0], 1);
    chk("t2_y12", y_out[1][2], 8);
    chk("t2_y21", y_out[2][1], 8);
    chk("t2_y03", y_out[0][3], 8);
    chk("t2_y33", y_out[3][3], 64);
    clr_m(1);
    run_tile();
    chk("t3_y00", y_out[0][0], 25);
    chk("t3_y02", y_out[0][2], 50);
    chk("t3_y22", y_out[2][2], 100);
    chk("t3_y33", y_out[3][3], 1);
    chk("t3_y03", y_out[0][3], 5);
    chk("t3_y10", y_out[1][0], 0);
    chk("t3_y21", y_out[2][1], 0);
    clr_m(0);
    m_in[3][3] = 32'h7FFF_FFFF;
    run_tile();
    chk("t4_y33", y_out[3][3], 32'hFFFF_FFC0);
    chk("t4_y00", y_out[0][0], 32'h7FFF_FFFF);
    chk("t4_y13", y_out[1][3], 32'hFFFF_FFF0);
    clr_m(0);
    m_in[3][3] = 1;
    start = 1;
    tick();
    clr_m(1);
    tick();
    chk("b2b_busy_e1", busy, 1);
    tick();
    chk("b2b_y33_e2", y_out[3][3], 64);
    chk("b2b_y12_e2", y_out[1][2], 8);
    tick();
    chk("b2b_done_e3", done, 1);
    tick();
    chk("b2b_busy_e4", busy, 1);
    chk("b2b_done_e4", done, 0);
    start = 0;
    tick();
    tick();
    chk("b2b_y22_e6", y_out[2][2], 100);
    chk("b2b_done_e6", done, 0);
    tick();
    chk("b2b_done_e7", done, 1);
    clr_m(0);
    m_in[0][0] = 1;
    start = 1;
    tick();
    start = 0;
    tick();
    rst = 1;
    start = 1;
    tick();
    chk("abort_y22", y_out[2][2], 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 0;
    start = 0;
    tick();
    chk("abort_done_e3", done, 0);
    tick();
    chk("abort_done_e4", done, 0);
    chk("abort_y00", y_out[0][0], 0);
    run_tile();
    chk("fresh_y00", y_out[0][0], 1);
    chk("fresh_y22", y_out[2][2], 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
